// File: rtl/ad_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_pkg
//  Description : Shared types and default constants for the ad_fifo phase
//                controller (state encoding, default parameter values and a
//                counter-width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package ad_fifo_pkg;

    // Controller states; 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Default parameter values
    localparam int C_DEF_ACC_W        = 4;
    localparam int C_DEF_THRESH       = 4;
    localparam int C_DEF_HOLDOFF      = 2;
    localparam int C_DEF_MAX_SKEW     = 8;
    localparam int C_DEF_FAULT_CYCLES = 4;

    // Width of a down-counter that has to hold values 0 .. n-1 (minimum 1 bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : ad_fifo_pkg
`default_nettype wire

// File: rtl/ad_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_ctrl
//  Description : Add/Drop controller for an adaptive FIFO. Integrates
//                early/late phase-detector pulses in a signed accumulator and
//                issues one-cycle Add/Drop pulses when the threshold is
//                crossed, with a holdoff window, a bounded net skew and a
//                timed FAULT state on FIFO overflow/underflow.
//                Optional build macro: AD_FIFO_CTRL_STATS_EN adds saturating
//                16-bit Add/Drop pulse counters (add_count_o, drop_count_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_fifo_ctrl
    import ad_fifo_pkg::*;
#(
    parameter int ACC_W        = C_DEF_ACC_W,
    parameter int THRESH       = C_DEF_THRESH,
    parameter int HOLDOFF      = C_DEF_HOLDOFF,
    parameter int MAX_SKEW     = C_DEF_MAX_SKEW,
    parameter int FAULT_CYCLES = C_DEF_FAULT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        edge_early_i,
    input  logic        edge_late_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    output logic        add_o,
    output logic        drop_o,
    output logic        fault_o,
    output logic        skew_limit_o,
    output logic        tracking_o
`ifdef AD_FIFO_CTRL_STATS_EN
    ,
    output logic [15:0] add_count_o,
    output logic [15:0] drop_count_o
`endif
);

    // Sum is one bit wider than the accumulator so the threshold compare can
    // never be fooled by wrap-around.
    localparam int C_SUM_W = ACC_W + 1;
    localparam int C_SKW_W = $clog2(MAX_SKEW) + 2;
    localparam int C_HCW   = cnt_width(HOLDOFF);
    localparam int C_FCW   = cnt_width(FAULT_CYCLES);

    localparam logic signed [C_SUM_W-1:0] C_THR_POS = C_SUM_W'(THRESH);
    localparam logic signed [C_SUM_W-1:0] C_THR_NEG = -C_THR_POS;
    localparam logic signed [C_SKW_W-1:0] C_SKW_POS = C_SKW_W'(MAX_SKEW);
    localparam logic signed [C_SKW_W-1:0] C_SKW_NEG = -C_SKW_POS;
    localparam logic [C_HCW-1:0]          C_HOLD_LD = C_HCW'(HOLDOFF - 1);
    localparam logic [C_FCW-1:0]          C_FLT_LD  = C_FCW'(FAULT_CYCLES - 1);
    // With no holdoff window a correction returns straight to TRACK
    localparam state_t                    C_POST_CORR = (HOLDOFF > 0) ? ST_HOLD : ST_TRACK;

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q,   acc_d;
    logic signed [C_SKW_W-1:0]  skew_q,  skew_d;
    logic [C_HCW-1:0]           hold_q,  hold_d;
    logic [C_FCW-1:0]           fcnt_q,  fcnt_d;
    logic                       add_q,   add_d;
    logic                       drop_q,  drop_d;

    logic signed [C_SUM_W-1:0]  w_delta;
    logic signed [C_SUM_W-1:0]  w_sum;
    logic                       w_fifo_err;
    logic                       w_at_pos;
    logic                       w_at_neg;

    // Phase step: simultaneous early and late pulses cancel
    always_comb begin
        w_delta = '0;
        if (edge_early_i && !edge_late_i) begin
            w_delta = C_SUM_W'(1);
        end else if (edge_late_i && !edge_early_i) begin
            w_delta = '1;
        end
    end

    assign w_sum      = {acc_q[ACC_W-1], acc_q} + w_delta;
    assign w_fifo_err = overflow_i | underflow_i;
    assign w_at_pos   = (skew_q == C_SKW_POS);
    assign w_at_neg   = (skew_q == C_SKW_NEG);

    // Next-state and datapath decode; FIFO errors beat enable, enable beats tracking
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        skew_d  = skew_q;
        hold_d  = hold_q;
        fcnt_d  = fcnt_q;
        add_d   = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d  = '0;
                skew_d = '0;
                if (w_fifo_err) begin
                    state_d = ST_FAULT;
                    fcnt_d  = C_FLT_LD;
                end else if (enable_i) begin
                    state_d = ST_TRACK;
                end
            end

            ST_TRACK: begin
                if (w_fifo_err) begin
                    state_d = ST_FAULT;
                    fcnt_d  = C_FLT_LD;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    skew_d  = '0;
                end else if (w_sum >= C_THR_POS) begin
                    // At the skew limit the crossing is absorbed silently
                    acc_d = '0;
                    if (!w_at_pos) begin
                        add_d   = 1'b1;
                        skew_d  = skew_q + C_SKW_W'(1);
                        state_d = C_POST_CORR;
                        hold_d  = C_HOLD_LD;
                    end
                end else if (w_sum <= C_THR_NEG) begin
                    acc_d = '0;
                    if (!w_at_neg) begin
                        drop_d  = 1'b1;
                        skew_d  = skew_q - C_SKW_W'(1);
                        state_d = C_POST_CORR;
                        hold_d  = C_HOLD_LD;
                    end
                end else begin
                    acc_d = w_sum[ACC_W-1:0];
                end
            end

            ST_HOLD: begin
                // Phase inputs are ignored here; only the window is timed
                if (w_fifo_err) begin
                    state_d = ST_FAULT;
                    fcnt_d  = C_FLT_LD;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    skew_d  = '0;
                end else if (hold_q == '0) begin
                    state_d = ST_TRACK;
                end else begin
                    hold_d = hold_q - C_HCW'(1);
                end
            end

            ST_FAULT: begin
                // FIFO flags are ignored while the fault dwell runs out
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    skew_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - C_FCW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                skew_d  = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            skew_q  <= '0;
            hold_q  <= '0;
            fcnt_q  <= '0;
            add_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            skew_q  <= skew_d;
            hold_q  <= hold_d;
            fcnt_q  <= fcnt_d;
            add_q   <= add_d;
            drop_q  <= drop_d;
        end
    end

    assign add_o        = add_q;
    assign drop_o       = drop_q;
    assign fault_o      = (state_q == ST_FAULT);
    assign tracking_o   = (state_q == ST_TRACK) || (state_q == ST_HOLD);
    assign skew_limit_o = w_at_pos | w_at_neg;

`ifdef AD_FIFO_CTRL_STATS_EN
    logic [15:0] add_cnt_q;
    logic [15:0] drop_cnt_q;

    // Saturating counts of pulses actually presented to the FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            add_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (add_q && (add_cnt_q != 16'hFFFF)) begin
                add_cnt_q <= add_cnt_q + 16'd1;
            end
            if (drop_q && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign add_count_o  = add_cnt_q;
    assign drop_count_o = drop_cnt_q;
`endif

endmodule : ad_fifo_ctrl
`default_nettype wire

// File: tb/tb_ad_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_fifo_ctrl
//  Description : Directed self-checking bench for ad_fifo_ctrl (default
//                parameters). Outputs are compared as the packed vector
//                {add, drop, fault, skew_limit, tracking}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_fifo_ctrl;

    logic clk_i = 1'b0;
    logic rst_i, enable_i, edge_early_i, edge_late_i, overflow_i, underflow_i;
    logic add_o, drop_o, fault_o, skew_limit_o, tracking_o;
`ifdef AD_FIFO_CTRL_STATS_EN
    logic [15:0] add_count_o, drop_count_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ad_fifo_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .edge_early_i (edge_early_i),
        .edge_late_i  (edge_late_i),
        .overflow_i   (overflow_i),
        .underflow_i  (underflow_i),
        .add_o        (add_o),
        .drop_o       (drop_o),
        .fault_o      (fault_o),
        .skew_limit_o (skew_limit_o),
        .tracking_o   (tracking_o)
`ifdef AD_FIFO_CTRL_STATS_EN
        ,
        .add_count_o  (add_count_o),
        .drop_count_o (drop_count_o)
`endif
    );

    // Advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Compare {add, drop, fault, skew_limit, tracking}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {add_o, drop_o, fault_o, skew_limit_o, tracking_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={add,drop,fault,slim,trk}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ph(input logic e, input logic l);
        edge_early_i = e;
        edge_late_i  = l;
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;
        ph(1'b0, 1'b0);
        #1;
        step(); step();
        chk("reset", 5'b00000);

        // Leave reset; IDLE -> TRACK
        rst_i = 1'b0; enable_i = 1'b1;
        step();
        chk("enter_track", 5'b00001);

        // Four early pulses -> Add one cycle after the 4th
        ph(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("early_acc%0d", i + 1), 5'b00001);
        end
        step(); chk("add_first", 5'b10001);
        // Early stays high during HOLD and must be ignored; Add is one cycle
        step(); chk("hold1_ignored", 5'b00001);
        step(); chk("hold2_ignored", 5'b00001);

        // Both edges together cancel for 10 cycles
        ph(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(); chk($sformatf("both_%0d", i), 5'b00001);
        end
        // Accumulator still 0: needs exactly 4 more early pulses
        ph(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("post_both_acc%0d", i + 1), 5'b00001);
        end
        step(); chk("post_both_add", 5'b10001);
        ph(1'b0, 1'b0);
        step(); step();

        // Accumulate 3, drop enable, re-enable: 4 fresh pulses needed
        ph(1'b1, 1'b0);
        step(); step(); step();
        chk("acc3_no_add", 5'b00001);
        enable_i = 1'b0; ph(1'b0, 1'b0);
        step(); chk("disable_idle", 5'b00000);
        enable_i = 1'b1;
        step(); chk("reenable_track", 5'b00001);
        ph(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("restart_acc%0d", i + 1), 5'b00001);
        end
        step(); chk("restart_add", 5'b10001);
        ph(1'b0, 1'b0);
        step(); step();

        // Clear skew, then 8 Drop bursts up to the negative limit
        enable_i = 1'b0; step();
        enable_i = 1'b1; step();
        chk("skew_cleared_track", 5'b00001);
        for (int b = 1; b <= 8; b++) begin
            ph(1'b0, 1'b1);
            step(); step(); step();
            chk($sformatf("burst%0d_pre", b), 5'b00001);
            step();
            chk($sformatf("burst%0d_drop", b), (b == 8) ? 5'b01011 : 5'b01001);
            ph(1'b0, 1'b0);
            step(); step();
        end
        // 9th burst: absorbed, no Drop, stays in TRACK with SkewLimit
        ph(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("burst9_%0d", i), 5'b00011);
        end
        ph(1'b0, 1'b0);
        step(); chk("burst9_after", 5'b00011);

        // Add still allowed at the negative limit: skew -8 -> -7
        ph(1'b1, 1'b0);
        step(); step(); step();
        step(); chk("add_from_limit", 5'b10001);
        // Next crossing puts us in HOLD (skew -6), then overflow hits
        ph(1'b0, 1'b0);
        step(); step();
        ph(1'b1, 1'b0);
        step(); step(); step();
        step(); chk("add_before_ovf", 5'b10001);
        ph(1'b0, 1'b0); overflow_i = 1'b1;
        step(); chk("fault1", 5'b00100);
        overflow_i = 1'b0; underflow_i = 1'b1;
        step(); chk("fault2_unf_ignored", 5'b00100);
        underflow_i = 1'b0;
        step(); chk("fault3", 5'b00100);
        step(); chk("fault4", 5'b00100);
        step(); chk("fault_exit_idle", 5'b00000);
        step(); chk("fault_retrack", 5'b00001);

        // Crossing coincident with overflow: no Add, FAULT wins
        ph(1'b1, 1'b0);
        step(); step(); step();
        overflow_i = 1'b1;
        step(); chk("ovf_blocks_add", 5'b00100);
        overflow_i = 1'b0; ph(1'b0, 1'b0);
        step(); step(); step();
        step(); chk("ovf2_idle", 5'b00000);
        step(); chk("ovf2_track", 5'b00001);

        // Reset on the crossing cycle: no Add, all outputs low
        ph(1'b1, 1'b0);
        step(); step(); step();
        rst_i = 1'b1;
        step(); chk("reset_on_cross", 5'b00000);
`ifdef AD_FIFO_CTRL_STATS_EN
        checks++;
        assert ({add_count_o, drop_count_o} === 32'h0) else begin
            errors++;
            $error("FAIL stats_reset observed=%h expected=%h", {add_count_o, drop_count_o}, 32'h0);
        end
`endif
        rst_i = 1'b0; ph(1'b0, 1'b0);
        step(); chk("after_reset_track", 5'b00001);
        step(); chk("after_reset_quiet", 5'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ad_fifo_ctrl
`default_nettype wire
